// File: rtl/dkong_video_pkg.sv
// Default Donkey Kong video timing constants and the shared timing-flag record.
package dkong_video_pkg;

  localparam int DKVT_CLK_DIV      = 2;
  localparam int DKVT_HW           = 10;
  localparam int DKVT_VW           = 9;
  localparam int DKVT_H_TOTAL      = 768;
  localparam int DKVT_H_BL_START   = 511;
  localparam int DKVT_H_BL_END     = 767;
  localparam int DKVT_H_SYNC_START = 576;
  localparam int DKVT_H_SYNC_END   = 640;
  localparam int DKVT_V_FIRST      = 504;
  localparam int DKVT_V_LAST       = 255;
  localparam int DKVT_V_BL_START   = 239;
  localparam int DKVT_V_BL_END     = 15;
  localparam int DKVT_V_SYNC_START = 504;
  localparam int DKVT_V_SYNC_END   = 0;

  // Active-high internal view of the four blank/sync flags.
  typedef struct packed {
    logic hblank;
    logic hsync;
    logic vblank;
    logic vsync;
  } dkvt_flags_t;

endpackage

// File: rtl/dkong_video_timing.sv
// Pixel divider, H/V raster counters, blank/sync flags and optional raster IRQ.
// Define DKVT_LINE_IRQ_EN to build the line-compare interrupt; otherwise O_IRQ is 0.
module dkong_video_timing
  import dkong_video_pkg::*;
#(
  parameter int CLK_DIV      = DKVT_CLK_DIV,
  parameter int HW           = DKVT_HW,
  parameter int VW           = DKVT_VW,
  parameter int H_TOTAL      = DKVT_H_TOTAL,
  parameter int H_BL_START   = DKVT_H_BL_START,
  parameter int H_BL_END     = DKVT_H_BL_END,
  parameter int H_SYNC_START = DKVT_H_SYNC_START,
  parameter int H_SYNC_END   = DKVT_H_SYNC_END,
  parameter int V_FIRST      = DKVT_V_FIRST,
  parameter int V_LAST       = DKVT_V_LAST,
  parameter int V_BL_START   = DKVT_V_BL_START,
  parameter int V_BL_END     = DKVT_V_BL_END,
  parameter int V_SYNC_START = DKVT_V_SYNC_START,
  parameter int V_SYNC_END   = DKVT_V_SYNC_END
) (
  input  logic          I_CLK,
  input  logic          I_RST_n,
  input  logic          I_VFLIP,
  input  logic [VW-1:0] I_IRQ_LINE,
  input  logic          I_IRQ_ACK,
  output logic          O_CE_PIX,
  output logic [HW-1:0] O_H_CNT,
  output logic [VW-1:0] O_V_CNT,
  output logic [VW-1:0] O_VF_CNT,
  output logic          O_HBLANK_n,
  output logic          O_VBLANK_n,
  output logic          O_CBLANK_n,
  output logic          O_HSYNC_n,
  output logic          O_VSYNC_n,
  output logic          O_IRQ
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          ce_pix;
  logic [HW-1:0] h_q;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_q;
  logic [VW-1:0] v_nxt;
  logic          v_adv;
  dkvt_flags_t   flags_q;

  // With CLK_DIV=1 the divider never leaves 0, so the enable is permanently high.
  assign ce_pix = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      div_q <= '0;
    end else if (ce_pix) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign h_nxt = (h_q == HW'(H_TOTAL - 1)) ? '0 : h_q + HW'(1);
  assign v_adv = (h_nxt == HW'(H_SYNC_START));
  assign v_nxt = (v_q == VW'(V_LAST)) ? VW'(V_FIRST) : v_q + VW'(1);

  // Flags follow the value being loaded; the set test comes last so START wins a tie.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      h_q            <= '0;
      flags_q.hblank <= 1'b0;
      flags_q.hsync  <= 1'b0;
    end else if (ce_pix) begin
      h_q <= h_nxt;
      if (h_nxt == HW'(H_BL_END))     flags_q.hblank <= 1'b0;
      if (h_nxt == HW'(H_BL_START))   flags_q.hblank <= 1'b1;
      if (h_nxt == HW'(H_SYNC_END))   flags_q.hsync  <= 1'b0;
      if (h_nxt == HW'(H_SYNC_START)) flags_q.hsync  <= 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      v_q            <= VW'(V_FIRST);
      flags_q.vblank <= 1'b1;
      flags_q.vsync  <= 1'b1;
    end else if (ce_pix && v_adv) begin
      v_q <= v_nxt;
      if (v_nxt == VW'(V_BL_END))     flags_q.vblank <= 1'b0;
      if (v_nxt == VW'(V_BL_START))   flags_q.vblank <= 1'b1;
      if (v_nxt == VW'(V_SYNC_END))   flags_q.vsync  <= 1'b0;
      if (v_nxt == VW'(V_SYNC_START)) flags_q.vsync  <= 1'b1;
    end
  end

`ifdef DKVT_LINE_IRQ_EN
  logic irq_q;

  // A new hit on the compare line outranks an acknowledge in the same cycle.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      irq_q <= 1'b0;
    end else if (ce_pix && v_adv && (v_nxt == I_IRQ_LINE)) begin
      irq_q <= 1'b1;
    end else if (I_IRQ_ACK) begin
      irq_q <= 1'b0;
    end
  end

  assign O_IRQ = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{I_IRQ_LINE, I_IRQ_ACK};
  assign O_IRQ             = 1'b0;
`endif

  assign O_CE_PIX   = ce_pix;
  assign O_H_CNT    = h_q;
  assign O_V_CNT    = v_q;
  assign O_VF_CNT   = v_q ^ {VW{I_VFLIP}};
  assign O_HBLANK_n = ~flags_q.hblank;
  assign O_VBLANK_n = ~flags_q.vblank;
  assign O_CBLANK_n = ~(flags_q.hblank | flags_q.vblank);
  assign O_HSYNC_n  = ~flags_q.hsync;
  assign O_VSYNC_n  = ~flags_q.vsync;

endmodule

// File: doc/dkong_video_timing.md
DKONG_VIDEO_TIMING -- requirements
Module: dkong_video_timing

Interface
REQ-001 CLK_DIV, 2, I_CLK cycles per pixel (>=1); 2 gives 12.288 MHz pixel rate from 24.576 MHz.
REQ-002 HW, 10, horizontal counter width.
REQ-003 VW, 9, vertical counter width; MSB-wrap supported.
REQ-004 H_TOTAL, 768, pixels per line; H counts 0..H_TOTAL-1.
REQ-005 H_BL_START, 511, H value at which hblank asserts.
REQ-006 H_BL_END, 767, H value at which hblank deasserts.
REQ-007 H_SYNC_START, 576, H value at which hsync asserts and V advances.
REQ-008 H_SYNC_END, 640, H value at which hsync deasserts.
REQ-009 V_FIRST, 504, V value loaded after V_LAST and at reset.
REQ-010 V_LAST, 255, final V value of a frame.
REQ-011 V_BL_START, 239, V value entering vblank.
REQ-012 V_BL_END, 15, V value leaving vblank.
REQ-013 V_SYNC_START, 504, V value entering vsync.
REQ-014 V_SYNC_END, 0, V value leaving vsync.
REQ-015 I_CLK  in  1  master clock.
REQ-016 I_RST_n  in  1  reset, asynchronous, active-low.
REQ-017 I_VFLIP  in  1  vertical flip select.
REQ-018 I_IRQ_LINE  in  VW  raster-interrupt compare line.
REQ-019 I_IRQ_ACK  in  1  interrupt acknowledge, sampled on I_CLK.
REQ-020 O_CE_PIX  out  1  pixel clock enable, one I_CLK cycle high per CLK_DIV cycles.
REQ-021 O_H_CNT  out  HW  horizontal pixel count.
REQ-022 O_V_CNT  out  VW  vertical line count.
REQ-023 O_VF_CNT  out  VW  O_V_CNT XOR {VW{I_VFLIP}}, combinational.
REQ-024 O_HBLANK_n  out  1  horizontal blank, active-low.
REQ-025 O_VBLANK_n  out  1  vertical blank, active-low.
REQ-026 O_CBLANK_n  out  1  low when either blank is active.
REQ-027 O_HSYNC_n  out  1  horizontal sync, active-low.
REQ-028 O_VSYNC_n  out  1  vertical sync, active-low.
REQ-029 O_IRQ  out  1  raster interrupt request, level, held until acknowledged.

Function
REQ-030 Divider: counts 0..CLK_DIV-1 and raises O_CE_PIX in the cycle its value is CLK_DIV-1; with CLK_DIV=1, O_CE_PIX is held high; all timing state advances only in cycles where O_CE_PIX is high.
REQ-031 H: increments on each CE and wraps H_TOTAL-1 -> 0; the line period is H_TOTAL*CLK_DIV I_CLK cycles.
REQ-032 H flags: registered; each sets/clears on the CE at which H equals the named H value; if two events share one H value, the START event is applied.
REQ-033 V: advances on the CE at which H equals H_SYNC_START; V_LAST -> V_FIRST, otherwise V+1 modulo 2^VW (511 -> 0 with default parameters).
REQ-034 V flags: registered; each updates in the same cycle V loads the matching value (vblank from V_BL_START up to V_BL_END exclusive; vsync from V_SYNC_START up to V_SYNC_END exclusive).
REQ-035 Line IRQ: O_IRQ sets on the V-advance cycle whose new V equals I_IRQ_LINE, and clears on a cycle with I_IRQ_ACK=1; set wins over a simultaneous ack; an I_IRQ_LINE value never reached produces no interrupt.
REQ-036 Outputs add no latency beyond the state registers; O_CBLANK_n = ~(hblank|vblank).

Reset
REQ-037 Reset is asynchronous; during reset: divider=0, O_CE_PIX=0 (1 if CLK_DIV=1), H=0, V=V_FIRST, O_HBLANK_n=1, O_HSYNC_n=1, O_VBLANK_n=0, O_VSYNC_n=0, O_IRQ=0.
REQ-038 Reset asserted mid-frame returns all state to these values immediately; counting resumes on the first I_CLK after release.

Configuration
REQ-039 DKVT_LINE_IRQ_EN defined: REQ-035 logic is present; undefined: O_IRQ is tied 0, I_IRQ_LINE and I_IRQ_ACK are ignored, and no IRQ register is built.

Structure
REQ-040 The default timing constants live in package dkong_video_pkg; the module is a single module with no sub-modules.

Verification
REQ-041 Defaults, release reset: first O_CE_PIX on the 2nd I_CLK; H 767->0 exactly every 1536 I_CLK cycles.
REQ-042 Defaults, one full frame: V sequence 504..511,0..255 (264 lines); O_VSYNC_n is low only for V=504..511; O_VBLANK_n is low only for V>=239 and V<=14 across the wrap.
REQ-043 Defaults: O_HBLANK_n low for H=511..766, O_HSYNC_n low for H=576..639; V changes in the same cycle as the H=576 CE.
REQ-044 I_IRQ_LINE=100: O_IRQ rises when V becomes 100; ack 10 cycles later -> O_IRQ=0; ack coincident with the next frame's set -> O_IRQ stays 1.
REQ-045 CLK_DIV=1 and CLK_DIV=4: line period is 768 and 3072 I_CLK cycles; I_VFLIP=1 at V=5 -> O_VF_CNT=506; reset mid-line -> H=0, V=504 asynchronously.
